// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU/result-select encodings, immediate
// formats and the decoded control bundle carried into the ID/EX register.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

  // B and J formats scramble their bits; both come out with bit0 = 0.
  function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_src_t src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// Two-read / one-write register file with x0 tied to zero, write-through
// bypass on both read ports and synchronous clear of every entry.
module register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs_reg [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) begin
          regs_reg[gi] <= '0;
        end
      end else begin : g_reg
        always_ff @(posedge clk) begin
          if (rst) begin
            regs_reg[gi] <= '0;
          end else if (we && (wa == AW'(gi))) begin
            regs_reg[gi] <= wd;
          end
        end
      end
    end
  endgenerate

  // A nonzero read address can only match a write to a real register,
  // so the bypass never leaks a discarded x0 write.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      rd1 = (we && (wa == ra1)) ? wd : regs_reg[ra1];
    end
    if (ra2 != '0) begin
      rd2 = (we && (wa == ra2)) ? wd : regs_reg[ra2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register-file
// reads and the ID/EX pipeline register feeding execute.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            IllegalE
);

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  ctrl_t           ctrl;
  imm_src_t        imm_src;
  logic            alu_ok;
  logic [2:0]      alu_op;
  idex_t           idex_reg;
  idex_t           idex_next;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign Rs1D      = InstrD[19:15];
  assign Rs2D      = InstrD[24:20];

  register_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // funct7[5] only distinguishes sub from add on R-type; I-type ignores it.
  always_comb begin
    alu_ok = 1'b1;
    alu_op = ALU_ADD;
    case (funct3)
      F3_ADD: alu_op = (opcode == OP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
      F3_SLT: alu_op = ALU_SLT;
      F3_OR:  alu_op = ALU_OR;
      F3_AND: alu_op = ALU_AND;
      default: alu_ok = 1'b0;
    endcase
    if (opcode == OP_RTYPE && funct7_b5 && funct3 != F3_ADD) begin
      alu_ok = 1'b0;
    end
  end

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.illegal    = (funct3 != F3_WORD);
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
        ctrl.illegal   = (funct3 != F3_WORD);
      end
      OP_RTYPE: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_op;
        ctrl.illegal     = !alu_ok;
      end
      OP_IALU: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_op;
        ctrl.illegal     = !alu_ok;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_src          = IMM_B;
        ctrl.illegal     = (funct3 != F3_BEQ);
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // An unsupported encoding must not leave any partial control asserted.
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

  always_comb begin
    idex_next = '0;
    if (!FlushE) begin
      idex_next.ctrl     = ctrl;
      idex_next.rd1      = rf_rd1;
      idex_next.rd2      = rf_rd2;
      idex_next.imm      = imm_extend(InstrD, imm_src);
      idex_next.pc       = PCD;
      idex_next.pc_plus4 = PCPlus4D;
      idex_next.rs1      = Rs1D;
      idex_next.rs2      = Rs2D;
      idex_next.rd       = InstrD[11:7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_reg <= '0;
    end else begin
      idex_reg <= idex_next;
    end
  end

  assign RegWriteE   = idex_reg.ctrl.reg_write;
  assign MemWriteE   = idex_reg.ctrl.mem_write;
  assign JumpE       = idex_reg.ctrl.jump;
  assign BranchE     = idex_reg.ctrl.branch;
  assign ALUSrcE     = idex_reg.ctrl.alu_src;
  assign ResultSrcE  = idex_reg.ctrl.result_src;
  assign ALUControlE = idex_reg.ctrl.alu_control;
  assign IllegalE    = idex_reg.ctrl.illegal;
  assign RD1E        = idex_reg.rd1;
  assign RD2E        = idex_reg.rd2;
  assign ImmExtE     = idex_reg.imm;
  assign PCE         = idex_reg.pc;
  assign PCPlus4E    = idex_reg.pc_plus4;
  assign Rs1E        = idex_reg.rs1;
  assign Rs2E        = idex_reg.rs2;
  assign RdE         = idex_reg.rd;

endmodule
